perf_event_dump: RTL



---
 rtl/perf_event_dump_if.sv | 9 +
 rtl/perf_event_dump.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/perf_event_dump_if.sv
// Byte stream from the event dumper to the UART TX FIFO (valid/ready).
interface perf_event_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/perf_event_dump.sv
// Counts rising edges on event strobes and streams periodic or triggered
// snapshots as ASCII hex text frames: <tag><hex digits>... CR LF.
module perf_event_dump #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PERIOD      = 60000,
  parameter int unsigned CLR_ON_SNAP = 0,
  parameter logic [7:0]  TAG_BASE    = 8'h61
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] evt_i,
  input  logic              trig_i,
  input  logic              clr_i,
  perf_event_dump_if.master tx,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int unsigned NIB   = CNT_W / 4;
  localparam int unsigned NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TMR_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB - 1);

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_DIGIT, S_CR, S_LF} state_e;

  state_e                         state_q, state_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic [NIB_W-1:0]               nib_q, nib_d;
  logic [NUM_CH-1:0]              prev_q, prev_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NUM_CH-1:0][CNT_W-1:0]   shadow_q, shadow_d;
  logic [TMR_W-1:0]               timer_q, timer_d;
  logic                           overrun_q, overrun_d;
  logic [7:0]                     tx_data_q, tx_data_d;
  logic                           tx_valid_q, tx_valid_d;
  logic                           busy_q, busy_d;
  logic [NUM_CH-1:0]              rise;
  logic                           snap_req, snap, fire;
  logic [CNT_W-1:0]               word;
  logic [3:0]                     nib_v;

  assign fire = tx_valid_q & tx.tx_ready;

  // Edge detect, saturating counters, snapshot timer and overrun flag
  always_comb begin
    prev_d    = evt_i;
    rise      = evt_i & ~prev_q;
    timer_d   = (timer_q == TMR_LAST) ? '0 : timer_q + TMR_W'(1);
    snap_req  = trig_i | (timer_q == TMR_LAST);
    snap      = snap_req && (state_q == S_IDLE);
    shadow_d  = shadow_q;
    cnt_inc   = cnt_q;
    cnt_d     = cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rise[k] && (cnt_q[k] != CNT_MAX)) cnt_inc[k] = cnt_q[k] + CNT_W'(1);
      if (clr_i)                              cnt_d[k] = '0;
      else if (snap && (CLR_ON_SNAP != 0))    cnt_d[k] = CNT_W'(rise[k]);
      else                                    cnt_d[k] = cnt_inc[k];
    end
    if (snap) shadow_d = cnt_inc;
    overrun_d = overrun_q;
    if (clr_i)                             overrun_d = 1'b0;
    else if (snap_req && state_q != S_IDLE) overrun_d = 1'b1;
  end

  // Frame sequencer: next state and byte position
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    nib_d   = nib_q;
    case (state_q)
      S_IDLE: if (snap) begin
        state_d = S_TAG;
        ch_d    = '0;
        nib_d   = '0;
      end
      S_TAG: if (fire) begin
        state_d = S_DIGIT;
        nib_d   = '0;
      end
      S_DIGIT: if (fire) begin
        if (nib_q == NIB_LAST) begin
          nib_d = '0;
          if (ch_q == CH_LAST) state_d = S_CR;
          else begin
            state_d = S_TAG;
            ch_d    = ch_q + CH_W'(1);
          end
        end else begin
          nib_d = nib_q + NIB_W'(1);
        end
      end
      S_CR:    if (fire) state_d = S_LF;
      S_LF:    if (fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output byte for the upcoming state, so outputs come straight from flops
  always_comb begin
    tx_valid_d = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
    word       = shadow_d[ch_d];
    nib_v      = '0;
    for (int i = 0; i < NIB; i++) begin
      if (nib_d == NIB_W'(i)) nib_v = word[4*(NIB-1-i) +: 4];
    end
    tx_data_d = '0;
    case (state_d)
      S_TAG:   tx_data_d = TAG_BASE + 8'(ch_d);
      S_DIGIT: tx_data_d = (nib_v < 4'd10) ? 8'h30 + 8'(nib_v) : 8'h37 + 8'(nib_v);
      S_CR:    tx_data_d = 8'h0D;
      S_LF:    tx_data_d = 8'h0A;
      default: tx_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ch_q       <= '0;
      nib_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      timer_q    <= '0;
      overrun_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      nib_q      <= nib_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      timer_q    <= timer_d;
      overrun_q  <= overrun_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule
